// File: rtl/key_switch_io.sv
`default_nettype none
// ============================================================================
// Module      : key_switch_io
// Description : Memory-mapped KEY/SW input device. Two-flop synchronizers,
//               per-group debounce, stable data registers and status
//               registers with sticky ready/overrun flags, served over a
//               simple address/read/write port with combinational read data.
// Revision    : 1.0 - initial release
// ============================================================================
module key_switch_io #(
  parameter int                DBITS           = 32,
  parameter int                DEBOUNCE_CYCLES = 100000,
  parameter int                CNT_BITS        = 17,
  parameter logic [DBITS-1:0]  ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] wrtData,
  output logic [DBITS-1:0] rdData,
  output logic             hit
);

  // Terminal count: a mismatch seen with the counter here is accepted.
  localparam logic [CNT_BITS-1:0] C_CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages
  logic [3:0]          key_s1_q, key_s2_q;
  logic [9:0]          sw_s1_q,  sw_s2_q;

  // Debounce state
  logic [3:0]          key_stable_q, key_stable_d;
  logic [9:0]          sw_stable_q,  sw_stable_d;
  logic [CNT_BITS-1:0] key_cnt_q,    key_cnt_d;
  logic [CNT_BITS-1:0] sw_cnt_q,     sw_cnt_d;
  logic                key_evt_w,    sw_evt_w;

  // Status flags
  logic                key_rdy_q, key_rdy_d;
  logic                key_ovr_q, key_ovr_d;
  logic                sw_rdy_q,  sw_rdy_d;
  logic                sw_ovr_q,  sw_ovr_d;

  // Access decode
  logic                sel_kdata_w, sel_sdata_w, sel_kctrl_w, sel_sctrl_w;
  logic                access_w;
  logic                kdata_rd_w,  sdata_rd_w;
  logic                kctrl_clr_w, sctrl_clr_w;
  logic                w_unused_wrdata;

  // Only bit 2 of store data has meaning; the rest are deliberately ignored.
  assign w_unused_wrdata = ^{wrtData[DBITS-1:3], wrtData[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode. A simultaneous read and write is treated as a write only,
  // so data-register reads are qualified with !wrtEn.
  // ---------------------------------------------------------------------------
  assign sel_kdata_w = (addr == ADDR_KDATA);
  assign sel_sdata_w = (addr == ADDR_SDATA);
  assign sel_kctrl_w = (addr == ADDR_KCTRL);
  assign sel_sctrl_w = (addr == ADDR_SCTRL);
  assign access_w    = rdEn | wrtEn;

  assign hit         = access_w & (sel_kdata_w | sel_sdata_w | sel_kctrl_w | sel_sctrl_w);

  assign kdata_rd_w  = rdEn & ~wrtEn & sel_kdata_w;
  assign sdata_rd_w  = rdEn & ~wrtEn & sel_sdata_w;
  assign kctrl_clr_w = wrtEn & sel_kctrl_w & ~wrtData[2];
  assign sctrl_clr_w = wrtEn & sel_sctrl_w & ~wrtData[2];

  // Read mux: data and status views of register state before the edge.
  always_comb begin
    rdData = '0;
    if (access_w) begin
      if (sel_kdata_w)      rdData = {{(DBITS-4){1'b0}}, ~key_stable_q};
      else if (sel_sdata_w) rdData = {{(DBITS-10){1'b0}}, sw_stable_q};
      else if (sel_kctrl_w) rdData = {{(DBITS-3){1'b0}}, key_ovr_q, 1'b0, key_rdy_q};
      else if (sel_sctrl_w) rdData = {{(DBITS-3){1'b0}}, sw_ovr_q, 1'b0, sw_rdy_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce next-state: count consecutive mismatching cycles, accept the new
  // value once the count reaches its terminal value, reset on any match.
  // ---------------------------------------------------------------------------
  assign key_evt_w = (key_s2_q != key_stable_q) && (key_cnt_q == C_CNT_MAX);
  assign sw_evt_w  = (sw_s2_q  != sw_stable_q)  && (sw_cnt_q  == C_CNT_MAX);

  // KEY group debounce next state
  always_comb begin
    key_stable_d = key_stable_q;
    key_cnt_d    = '0;
    if (key_s2_q != key_stable_q) begin
      if (key_evt_w) key_stable_d = key_s2_q;
      else           key_cnt_d    = key_cnt_q + 1'b1;
    end
  end

  // SW group debounce next state
  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    if (sw_s2_q != sw_stable_q) begin
      if (sw_evt_w) sw_stable_d = sw_s2_q;
      else          sw_cnt_d    = sw_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Flag next-state. A change event sets ready even if a read happens on the
  // same edge (the read returned the old value). Overrun is set only when an
  // unread value is overwritten; that set beats a clearing status write.
  // ---------------------------------------------------------------------------
  // KEY status flags next state
  always_comb begin
    key_rdy_d = key_rdy_q;
    key_ovr_d = key_ovr_q;
    if (key_evt_w)       key_rdy_d = 1'b1;
    else if (kdata_rd_w) key_rdy_d = 1'b0;
    if (key_evt_w && key_rdy_q && !kdata_rd_w) key_ovr_d = 1'b1;
    else if (kctrl_clr_w)                      key_ovr_d = 1'b0;
  end

  // SW status flags next state
  always_comb begin
    sw_rdy_d = sw_rdy_q;
    sw_ovr_d = sw_ovr_q;
    if (sw_evt_w)        sw_rdy_d = 1'b1;
    else if (sdata_rd_w) sw_rdy_d = 1'b0;
    if (sw_evt_w && sw_rdy_q && !sdata_rd_w) sw_ovr_d = 1'b1;
    else if (sctrl_clr_w)                    sw_ovr_d = 1'b0;
  end

  // Two-flop synchronizers; KEY idles high (active-low buttons).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= 4'hF;
      key_s2_q <= 4'hF;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce counters and stable registers; reset discards any pending change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_stable_q <= 4'hF;
      sw_stable_q  <= '0;
      key_cnt_q    <= '0;
      sw_cnt_q     <= '0;
    end else begin
      key_stable_q <= key_stable_d;
      sw_stable_q  <= sw_stable_d;
      key_cnt_q    <= key_cnt_d;
      sw_cnt_q     <= sw_cnt_d;
    end
  end

  // Sticky ready/overrun flags for both groups.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_rdy_q <= 1'b0;
      key_ovr_q <= 1'b0;
      sw_rdy_q  <= 1'b0;
      sw_ovr_q  <= 1'b0;
    end else begin
      key_rdy_q <= key_rdy_d;
      key_ovr_q <= key_ovr_d;
      sw_rdy_q  <= sw_rdy_d;
      sw_ovr_q  <= sw_ovr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_switch_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_switch_io
// Description : Directed self-checking bench for key_switch_io with a short
//               debounce window (4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_switch_io;

  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam logic [31:0] A_NONE  = 32'hF0000020;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr;
  logic        rdEn, wrtEn;
  logic [31:0] wrtData;
  logic [31:0] rdData;
  logic        hit;

  int vectors    = 0;
  int miscompares = 0;

  key_switch_io #(
    .DBITS          (32),
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS       (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .KEY    (KEY),
    .SW     (SW),
    .addr   (addr),
    .rdEn   (rdEn),
    .wrtEn  (wrtEn),
    .wrtData(wrtData),
    .rdData (rdData),
    .hit    (hit)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-time-side-effect read between edges: check data and hit.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    addr = a; rdEn = 1'b1; wrtEn = 1'b0;
    #1;
    chk(tag, rdData, exp);
    chk({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
    rdEn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY = 4'hF; SW = '0;
    addr = '0; rdEn = 1'b0; wrtEn = 1'b0; wrtData = '0;

    // 1. Reset state
    tick(); tick();
    rd("rst_kdata", A_KDATA, 32'h0, 1'b1);
    rd("rst_sdata", A_SDATA, 32'h0, 1'b1);
    rd("rst_kctrl", A_KCTRL, 32'h0, 1'b1);
    rd("rst_sctrl", A_SCTRL, 32'h0, 1'b1);
    tick();
    rd("rst_unmapped", A_NONE, 32'h0, 1'b0);
    reset = 1'b0;
    tick(); tick();

    // 2. Press KEY[1]; accepted at edge k+5
    KEY = 4'hD;
    repeat (5) tick();
    rd("press_early_kdata", A_KDATA, 32'h0, 1'b1);
    rd("press_early_kctrl", A_KCTRL, 32'h0, 1'b1);
    tick();
    rd("press_kdata", A_KDATA, 32'h2, 1'b1);
    rd("press_kctrl", A_KCTRL, 32'h1, 1'b1);

    // 3. SW[3] bounce: high 3 cycles, low 3 cycles, twice
    for (int r = 0; r < 2; r++) begin
      SW = 10'h008;
      repeat (3) tick();
      SW = 10'h000;
      repeat (3) tick();
      rd("bounce_sdata", A_SDATA, 32'h0, 1'b1);
      rd("bounce_sctrl", A_SCTRL, 32'h0, 1'b1);
    end
    repeat (4) tick();
    rd("bounce_final_sdata", A_SDATA, 32'h0, 1'b1);

    // 4. Second change without a read -> overrun
    KEY = 4'hF;
    repeat (6) tick();
    rd("ovr_kctrl", A_KCTRL, 32'h5, 1'b1);
    rd("ovr_kdata", A_KDATA, 32'h0, 1'b1);
    addr = A_KDATA; rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    rd("after_read_kctrl", A_KCTRL, 32'h4, 1'b1);
    addr = A_KCTRL; wrtEn = 1'b1; wrtData = 32'h4;
    #1;
    chk("wr_hit", {31'b0, hit}, 32'h1);
    tick();
    wrtEn = 1'b0;
    rd("wr4_keeps_ovr", A_KCTRL, 32'h4, 1'b1);
    addr = A_KCTRL; wrtEn = 1'b1; wrtData = 32'h0;
    tick();
    wrtEn = 1'b0;
    rd("wr0_clears", A_KCTRL, 32'h0, 1'b1);
    addr = A_KCTRL; wrtEn = 1'b1; wrtData = 32'h4;
    tick();
    wrtEn = 1'b0;
    rd("wr4_after_clear", A_KCTRL, 32'h0, 1'b1);

    // 5. Read KDATA on the same edge as an accepted change
    KEY = 4'hE;
    repeat (6) tick();
    rd("pre_sim_kctrl", A_KCTRL, 32'h1, 1'b1);
    rd("pre_sim_kdata", A_KDATA, 32'h1, 1'b1);
    KEY = 4'hA;
    repeat (5) tick();
    addr = A_KDATA; rdEn = 1'b1;
    #1;
    chk("sim_old_value", rdData, 32'h1);
    tick();
    rdEn = 1'b0;
    rd("sim_kctrl", A_KCTRL, 32'h1, 1'b1);
    rd("sim_kdata", A_KDATA, 32'h5, 1'b1);
    // Read and write together act as a write: ready must survive.
    addr = A_KDATA; rdEn = 1'b1; wrtEn = 1'b1; wrtData = 32'h0;
    tick();
    rdEn = 1'b0; wrtEn = 1'b0;
    rd("rdwr_no_clear", A_KCTRL, 32'h1, 1'b1);

    // 6. Reset while SW debounce counter is at 2
    SW = 10'h3FF;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    rd("midrst_sdata", A_SDATA, 32'h0, 1'b1);
    rd("midrst_kctrl", A_KCTRL, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    rd("rel5_sdata", A_SDATA, 32'h0, 1'b1);
    rd("rel5_sctrl", A_SCTRL, 32'h0, 1'b1);
    tick();
    rd("rel6_sdata", A_SDATA, 32'h3FF, 1'b1);
    rd("rel6_sctrl", A_SCTRL, 32'h1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_switch_io.md
# key_switch_io

Memory-mapped input device for the board's KEY and SW pins, sitting directly upstream of the memory unit in the pipelined processor's writeback-side memory stage. It synchronizes and debounces the raw pins, and keeps a stable, pressed-high KEY data register and a stable SW data register. Each register has a status register with a sticky ready flag and a sticky overrun flag. The memory unit's load/store path reads the device over a simple address/read/write port.

## Interface
- DBITS, 32, data/address width
- DEBOUNCE_CYCLES, 100000, number of consecutive stable cycles required to accept a new input value (≥2)
- CNT_BITS, 17, debounce counter width (must hold DEBOUNCE_CYCLES-1)
- ADDR_KDATA, 32'hF0000010, KEY data register (read-only)
- ADDR_SDATA, 32'hF0000014, SW data register (read-only)
- ADDR_KCTRL, 32'hF0000110, KEY status register
- ADDR_SCTRL, 32'hF0000114, SW status register

Ports:
- clk  in  1  system clock; single clock domain, all state on rising edge
- reset  in  1  asynchronous, active-high
- KEY  in  4  raw push buttons, active-low (asynchronous)
- SW  in  10  raw slide switches (asynchronous)
- addr  in  DBITS  access address from the memory stage
- rdEn  in  1  load access this cycle
- wrtEn  in  1  store access this cycle
- wrtData  in  DBITS  store data
- rdData  out  DBITS  combinational read data; 0 when not hit
- hit  out  1  combinational; addr matches one of the four addresses and (rdEn or wrtEn)

## Operation
- Synchronizer: two flops per bit. On reset, KEY flops = 1 and SW flops = 0.
- Debounce is per group (KEY, SW). Each group has one counter and one stable register:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0, change event = 1.
  - A mismatch that ends before acceptance returns the counter to 0 and leaves stable unchanged (bounce rejection).
- Reset values: stable KEY = 4'hF (nothing pressed), stable SW = 0, counters = 0, all flags = 0.
- KDATA = {28'b0, ~stableKEY}, so a pressed button reads as 1. SDATA = {22'b0, stableSW}.
- Status register layout: bit0 = ready, bit2 = overrun, all other bits read 0.
- A read access is rdEn && addr == data address. On a data read:
  - The register value is returned the same cycle.
  - The group's ready clears on that clock edge.
- On a change event:
  - ready <= 1.
  - If ready was already 1 and no data read is happening on the same edge, overrun <= 1.
- Change event and data read on the same edge: ready stays 1 and overrun is unchanged. The read consumed the old value.
- Status write (wrtEn && addr == ctrl address):
  - wrtData[2] == 0 clears overrun.
  - wrtData[2] == 1 has no effect.
  - bit0 is read-only.
  - If a change event would set overrun on the same edge, the set wins.
- Writes to data registers and accesses to any other address have no effect. rdData = 0 and hit = 0 for unmapped addresses.
- rdEn and wrtEn both high: treat as a write only; no read side effect.

## Timing
- Pin change to stable: raw change before edge k → sync1 at edge k → sync2 at edge k+1 → stable, ready and KDATA/SDATA update at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges in total).
- rdData and hit: zero-latency combinational decode of addr/rdEn/wrtEn. They reflect register state before the current edge.
- Flag side effects (clear on read, clear by write) take effect at the access edge and are visible the next cycle.
- Reset mid-debounce: the counter drops to 0 and the pending change is discarded. After release, an input held at its changed value is re-accepted DEBOUNCE_CYCLES+2 edges later.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

## Test plan
(All with DEBOUNCE_CYCLES=4.)
1. Reset: assert reset with KEY=4'hF, SW=0, then read all four addresses → KDATA=0, SDATA=0, KCTRL=0, SCTRL=0, hit=1 each; unmapped 32'hF0000020 → rdData=0, hit=0.
2. Press KEY[1] (KEY=4'hD) before edge k → KDATA=32'h2 and KCTRL=32'h1 first visible after edge k+5, not earlier.
3. Bounce: SW[3] toggles high for 3 cycles then low, repeat twice → SDATA stays 0 and SCTRL stays 0.
4. Ready/overrun: two accepted KEY changes with no read → KCTRL=32'h5. Then read KDATA → next KCTRL=32'h4. Write KCTRL with 0 → KCTRL=0. Write 32'h4 → unchanged.
5. Simultaneous: KDATA read on the same edge a SW-independent KEY change is accepted (ready=1 beforehand) → KCTRL=32'h1, overrun 0.
6. Reset mid-debounce: SW=10'h3FF, reset asserted at counter=2 then released → SDATA=0 until 6 edges after release, then 32'h3FF with SCTRL=32'h1.
